// File: rtl/scan_sequencer_pkg.sv
// scan_pkg: shared types and constants for the bar-code frame sequencer.
//   state_t      - frame FSM states
//   CODE_START / CODE_STOP - 5-bit control symbols
//   ERR_*        - end-of-frame status codes
//   W0..W4       - 2-of-5 bit weights
//   add_mod10    - checksum accumulate helper
package scan_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA  = 2'd1,
    CHECK = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam logic [4:0] CODE_START = 5'b00111;
  localparam logic [4:0] CODE_STOP  = 5'b11100;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_BADSYM   = 2'd1;
  localparam logic [1:0] ERR_CHECKSUM = 2'd2;
  localparam logic [1:0] ERR_ABORT    = 2'd3;

  localparam logic [3:0] W0 = 4'd1;
  localparam logic [3:0] W1 = 4'd2;
  localparam logic [3:0] W2 = 4'd4;
  localparam logic [3:0] W3 = 4'd7;
  localparam logic [3:0] W4 = 4'd0;

  // The sum of two digits can reach 18, so widen before folding back into 0..9.
  function automatic logic [3:0] add_mod10(input logic [3:0] a, input logic [3:0] b);
    logic [4:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= 5'd10) begin
      s = s - 5'd10;
    end else begin
      s = s;
    end
    return s[3:0];
  endfunction

endpackage

// File: rtl/scan_sequencer_if.sv
// scan_sequencer_if: symbol input and frame result bundle.
//   PG, I                           - symbol strobe and code from the front end
//   digit_valid, digit              - accepted data digit pulse
//   FIM, ERR, err_code              - end-of-frame pulse and status
//   busy                            - frame in progress
// master = symbol source / result consumer, slave = sequencer.
interface scan_sequencer_if;
  logic       PG;
  logic [4:0] I;
  logic       digit_valid;
  logic [3:0] digit;
  logic       FIM;
  logic       ERR;
  logic [1:0] err_code;
  logic       busy;

  modport master (
    output PG, I,
    input  digit_valid, digit, FIM, ERR, err_code, busy
  );

  modport slave (
    input  PG, I,
    output digit_valid, digit, FIM, ERR, err_code, busy
  );
endinterface

// File: rtl/scan_sequencer_twoof5_decode.sv
// twoof5_decode: combinational 2-of-5 symbol decoder.
//   I        in  - 5-bit symbol code
//   valid    out - exactly two bits set (a data digit)
//   digit    out - weighted value, 11 folded to 0; 0 when not valid
//   is_start out - symbol equals the START control code
//   is_stop  out - symbol equals the STOP control code
module twoof5_decode
  import scan_pkg::*;
(
  input  logic [4:0] I,
  output logic       valid,
  output logic [3:0] digit,
  output logic       is_start,
  output logic       is_stop
);

  logic [2:0] ones_s;
  logic [3:0] wsum_s;

  // Count set bits and form the weighted sum of the set positions.
  always_comb begin
    ones_s = {2'b00, I[0]} + {2'b00, I[1]} + {2'b00, I[2]} + {2'b00, I[3]} + {2'b00, I[4]};
    wsum_s = (I[0] ? W0 : 4'd0) + (I[1] ? W1 : 4'd0) + (I[2] ? W2 : 4'd0)
           + (I[3] ? W3 : 4'd0) + (I[4] ? W4 : 4'd0);
    valid  = (ones_s == 3'd2);
    if (!valid) begin
      digit = 4'd0;
    end else if (wsum_s == 4'd11) begin
      digit = 4'd0;
    end else begin
      digit = wsum_s;
    end
    is_start = (I == CODE_START);
    is_stop  = (I == CODE_STOP);
  end

endmodule

// File: rtl/scan_sequencer.sv
// scan_sequencer: frames bar-code scans as START, DIGITS data digits,
// check digit, STOP; reports one end-of-frame event with status.
//   clock                - rising-edge clock
//   I_StateMachine_Reset - synchronous active-high reset
//   bus (slave)          - PG/I symbol input, digit/FIM/ERR/err_code/busy results
// Parameters: DIGITS data digits per frame (1..15), TIMEOUT max inter-symbol gap.
module scan_sequencer
  import scan_pkg::*;
#(
  parameter int DIGITS  = 4,
  parameter int TIMEOUT = 255
) (
  input  logic             clock,
  input  logic             I_StateMachine_Reset,
  scan_sequencer_if.slave  bus
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int CW = $clog2(DIGITS + 1);
  localparam logic [TW-1:0] TIMER_LIMIT = TW'(TIMEOUT);
  localparam logic [TW-1:0] TIMER_SAT   = {TW{1'b1}};
  localparam logic [CW-1:0] LAST_COUNT  = CW'(DIGITS - 1);

  state_t        state_r;
  logic          pg_q_r;
  logic [TW-1:0] timer_r;
  logic [CW-1:0] count_r;
  logic [3:0]    sum_r;
  logic          digit_valid_r;
  logic [3:0]    digit_r;
  logic          fim_r;
  logic          err_r;
  logic [1:0]    err_code_r;
  logic          busy_r;

  logic          acc_s;
  logic          sym_valid_s;
  logic [3:0]    sym_digit_s;
  logic          sym_start_s;
  logic          sym_stop_s;

  twoof5_decode u_decode (
    .I        (bus.I),
    .valid    (sym_valid_s),
    .digit    (sym_digit_s),
    .is_start (sym_start_s),
    .is_stop  (sym_stop_s)
  );

  // A symbol is consumed only on the rising edge of PG.
  assign acc_s = bus.PG & ~pg_q_r;

  // Frame FSM with gap timer, checksum accumulator and registered outputs.
  always_ff @(posedge clock) begin
    if (I_StateMachine_Reset) begin
      state_r       <= IDLE;
      pg_q_r        <= 1'b1;  // PG held high across release must not look like an edge
      timer_r       <= '0;
      count_r       <= '0;
      sum_r         <= 4'd0;
      digit_valid_r <= 1'b0;
      digit_r       <= 4'd0;
      fim_r         <= 1'b0;
      err_r         <= 1'b0;
      err_code_r    <= ERR_NONE;
      busy_r        <= 1'b0;
    end else begin
      pg_q_r        <= bus.PG;
      digit_valid_r <= 1'b0;
      digit_r       <= 4'd0;
      fim_r         <= 1'b0;
      err_r         <= 1'b0;
      err_code_r    <= ERR_NONE;

      // An accepted symbol beats a coincident timeout because it clears the timer.
      if (state_r == IDLE || acc_s) begin
        timer_r <= '0;
      end else if (timer_r != TIMER_SAT) begin
        timer_r <= timer_r + TW'(1);
      end else begin
        timer_r <= timer_r;
      end

      case (state_r)
        IDLE: begin
          if (acc_s && sym_start_s) begin
            state_r <= DATA;
            count_r <= '0;
            sum_r   <= 4'd0;
            busy_r  <= 1'b1;
          end else begin
            state_r <= IDLE;
          end
        end

        DATA, CHECK, STOP: begin
          if (acc_s) begin
            if (sym_start_s) begin
              // A fresh START aborts the current frame and opens a new one directly.
              fim_r      <= 1'b1;
              err_r      <= 1'b1;
              err_code_r <= ERR_ABORT;
              state_r    <= DATA;
              count_r    <= '0;
              sum_r      <= 4'd0;
              busy_r     <= 1'b1;
            end else begin
              case (state_r)
                DATA: begin
                  if (sym_valid_s) begin
                    digit_valid_r <= 1'b1;
                    digit_r       <= sym_digit_s;
                    sum_r         <= add_mod10(sum_r, sym_digit_s);
                    count_r       <= count_r + CW'(1);
                    if (count_r == LAST_COUNT) begin
                      state_r <= CHECK;
                    end else begin
                      state_r <= DATA;
                    end
                  end else begin
                    fim_r      <= 1'b1;
                    err_r      <= 1'b1;
                    err_code_r <= ERR_BADSYM;
                    state_r    <= IDLE;
                    busy_r     <= 1'b0;
                  end
                end
                CHECK: begin
                  if (sym_valid_s && (sym_digit_s == sum_r)) begin
                    state_r <= STOP;
                  end else if (sym_valid_s) begin
                    fim_r      <= 1'b1;
                    err_r      <= 1'b1;
                    err_code_r <= ERR_CHECKSUM;
                    state_r    <= IDLE;
                    busy_r     <= 1'b0;
                  end else begin
                    fim_r      <= 1'b1;
                    err_r      <= 1'b1;
                    err_code_r <= ERR_BADSYM;
                    state_r    <= IDLE;
                    busy_r     <= 1'b0;
                  end
                end
                STOP: begin
                  if (sym_stop_s) begin
                    fim_r      <= 1'b1;
                    err_r      <= 1'b0;
                    err_code_r <= ERR_NONE;
                  end else begin
                    fim_r      <= 1'b1;
                    err_r      <= 1'b1;
                    err_code_r <= ERR_BADSYM;
                  end
                  state_r <= IDLE;
                  busy_r  <= 1'b0;
                end
                default: begin
                  state_r <= IDLE;
                  busy_r  <= 1'b0;
                end
              endcase
            end
          end else if (timer_r == TIMER_LIMIT) begin
            fim_r      <= 1'b1;
            err_r      <= 1'b1;
            err_code_r <= ERR_ABORT;
            state_r    <= IDLE;
            busy_r     <= 1'b0;
          end else begin
            state_r <= state_r;
          end
        end

        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.digit_valid = digit_valid_r;
  assign bus.digit       = digit_r;
  assign bus.FIM         = fim_r;
  assign bus.ERR         = err_r;
  assign bus.err_code    = err_code_r;
  assign bus.busy        = busy_r;

endmodule

// File: tb/tb_scan_sequencer.sv
// tb_scan_sequencer: directed self-checking bench for scan_sequencer
// (DIGITS=4, TIMEOUT=8). Symbols are driven one every two cycles.
module tb_scan_sequencer;

  localparam logic [4:0] S_START = 5'b00111;
  localparam logic [4:0] S_STOP  = 5'b11100;
  localparam logic [4:0] S_D0    = 5'b01100;
  localparam logic [4:0] S_D1    = 5'b10001;
  localparam logic [4:0] S_D2    = 5'b10010;
  localparam logic [4:0] S_D3    = 5'b00011;
  localparam logic [4:0] S_D4    = 5'b10100;
  localparam logic [4:0] S_BAD   = 5'b11111;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;
  int   dv_cnt;
  int   fim_cnt;
  int   stray_cnt;

  scan_sequencer_if bus ();

  scan_sequencer #(.DIGITS(4), .TIMEOUT(8)) dut (
    .clock                (clk),
    .I_StateMachine_Reset (rst),
    .bus                  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse monitor sampled on the falling edge.
  always @(negedge clk) begin
    if (bus.digit_valid === 1'b1) dv_cnt <= dv_cnt + 1;
    if (bus.FIM === 1'b1) fim_cnt <= fim_cnt + 1;
    if (bus.FIM === 1'b0 && (bus.ERR !== 1'b0 || bus.err_code !== 2'd0)) stray_cnt <= stray_cnt + 1;
  end

  initial begin
    dv_cnt = 0;
    fim_cnt = 0;
    stray_cnt = 0;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (obs !== exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One symbol: PG high one cycle, then low; returns just after the accepting edge.
  task automatic send_sym(input logic [4:0] code);
    @(posedge clk); #1;
    bus.PG = 1'b1;
    bus.I  = code;
    @(posedge clk); #1;
    bus.PG = 1'b0;
    bus.I  = 5'd0;
  endtask

  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int dv0;
    int f0;
    int lat;
    n_checks = 0;
    n_errors = 0;
    rst    = 1'b1;
    bus.PG = 1'b1;
    bus.I  = S_START;

    // Reset with PG held high through release.
    idle_cycles(3);
    check_val("rst_fim", 32'(bus.FIM), 32'd0);
    check_val("rst_dv", 32'(bus.digit_valid), 32'd0);
    check_val("rst_busy", 32'(bus.busy), 32'd0);
    check_val("rst_code", 32'(bus.err_code), 32'd0);
    rst = 1'b0;
    idle_cycles(3);
    check_val("rst_release_no_acc", 32'(bus.busy), 32'd0);
    bus.PG = 1'b0;
    idle_cycles(2);

    // Good frame 1,2,3,4 check 0.
    dv0 = dv_cnt; f0 = fim_cnt;
    send_sym(S_START);
    check_val("good_busy", 32'(bus.busy), 32'd1);
    send_sym(S_D1);
    check_val("good_dv1", 32'(bus.digit_valid), 32'd1);
    check_val("good_d1", 32'(bus.digit), 32'd1);
    send_sym(S_D2);
    check_val("good_d2", 32'(bus.digit), 32'd2);
    send_sym(S_D3);
    check_val("good_d3", 32'(bus.digit), 32'd3);
    send_sym(S_D4);
    check_val("good_d4", 32'(bus.digit), 32'd4);
    send_sym(S_D0);
    check_val("good_chk_nofim", 32'(bus.FIM), 32'd0);
    check_val("good_chk_nodv", 32'(bus.digit_valid), 32'd0);
    send_sym(S_STOP);
    check_val("good_fim", 32'(bus.FIM), 32'd1);
    check_val("good_err", 32'(bus.ERR), 32'd0);
    check_val("good_code", 32'(bus.err_code), 32'd0);
    check_val("good_busy_end", 32'(bus.busy), 32'd0);
    idle_cycles(1);
    check_val("good_fim_pulse", 32'(bus.FIM), 32'd0);
    idle_cycles(1);
    check_val("good_dv_count", 32'(dv_cnt - dv0), 32'd4);
    check_val("good_fim_count", 32'(fim_cnt - f0), 32'd1);

    // Checksum error: check digit 1 instead of 0.
    f0 = fim_cnt;
    send_sym(S_START);
    send_sym(S_D1);
    send_sym(S_D2);
    send_sym(S_D3);
    send_sym(S_D4);
    send_sym(S_D1);
    check_val("cks_fim", 32'(bus.FIM), 32'd1);
    check_val("cks_err", 32'(bus.ERR), 32'd1);
    check_val("cks_code", 32'(bus.err_code), 32'd2);
    check_val("cks_busy", 32'(bus.busy), 32'd0);
    send_sym(S_STOP);
    check_val("cks_stop_ignored", 32'(bus.FIM), 32'd0);
    idle_cycles(1);
    check_val("cks_fim_count", 32'(fim_cnt - f0), 32'd1);

    // Bad symbol as third symbol.
    dv0 = dv_cnt;
    send_sym(S_START);
    send_sym(S_D1);
    send_sym(S_BAD);
    check_val("bad_fim", 32'(bus.FIM), 32'd1);
    check_val("bad_err", 32'(bus.ERR), 32'd1);
    check_val("bad_code", 32'(bus.err_code), 32'd1);
    idle_cycles(1);
    check_val("bad_dv_count", 32'(dv_cnt - dv0), 32'd1);

    // Timeout: timer reaches 8 eight edges after the digit, FIM one edge later.
    send_sym(S_START);
    send_sym(S_D1);
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (bus.FIM === 1'b1 && lat == 0) begin
        lat = k;
        check_val("tmo_code", 32'(bus.err_code), 32'd3);
        check_val("tmo_err", 32'(bus.ERR), 32'd1);
        check_val("tmo_busy", 32'(bus.busy), 32'd0);
      end
    end
    check_val("tmo_latency", 32'(lat), 32'd9);

    // START mid-DATA aborts and restarts without a new START.
    dv0 = dv_cnt;
    send_sym(S_START);
    send_sym(S_D1);
    send_sym(S_START);
    check_val("rs_fim", 32'(bus.FIM), 32'd1);
    check_val("rs_code", 32'(bus.err_code), 32'd3);
    check_val("rs_busy", 32'(bus.busy), 32'd1);
    send_sym(S_D1);
    send_sym(S_D2);
    send_sym(S_D3);
    send_sym(S_D4);
    send_sym(S_D0);
    send_sym(S_STOP);
    check_val("rs_good_fim", 32'(bus.FIM), 32'd1);
    check_val("rs_good_err", 32'(bus.ERR), 32'd0);
    check_val("rs_good_code", 32'(bus.err_code), 32'd0);
    idle_cycles(1);
    check_val("rs_dv_count", 32'(dv_cnt - dv0), 32'd5);

    // PG held high with START for 6 cycles: exactly one acc.
    f0 = fim_cnt;
    @(posedge clk); #1;
    bus.PG = 1'b1;
    bus.I  = S_START;
    idle_cycles(6);
    bus.PG = 1'b0;
    bus.I  = 5'd0;
    check_val("hold_busy", 32'(bus.busy), 32'd1);
    check_val("hold_no_abort", 32'(fim_cnt - f0), 32'd0);

    // Reset during DATA: dropped silently.
    send_sym(S_D2);
    check_val("mid_dv", 32'(bus.digit_valid), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_val("mid_rst_busy", 32'(bus.busy), 32'd0);
    check_val("mid_rst_dv", 32'(bus.digit_valid), 32'd0);
    check_val("mid_rst_fim", 32'(bus.FIM), 32'd0);
    send_sym(S_D3);
    check_val("mid_idle_no_dv", 32'(bus.digit_valid), 32'd0);
    idle_cycles(12);
    check_val("mid_no_fim", 32'(fim_cnt - f0), 32'd0);
    check_val("stray_status", 32'(stray_cnt), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
